wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Single-outstanding Wishbone classic initiator that turns word-wide read/write commands from a valid/ready command port into bus cycles and returns the result on a valid/ready response port. It drives the same 32-bit Wishbone bus that the peripheral responders (GPIO, timer, UART) sit on. It is used by debug and DMA-style logic that needs bus access without the CPU. An optional watchdog aborts cycles that are never acknowledged.

## Interface
- TIMEOUT, 1024: bus-cycle watchdog limit in clk cycles; legal range 2..65535; used only with the watchdog compiled in.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  byte address, passed unmodified.
- cmd_sel  in  4  byte selects.
- cmd_dat  in  32  write data.
- rsp_valid / rsp_ready  out / in  1  response handshake.
- rsp_dat  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  1 = bus error or timeout.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone control.
- wb_adr_o  out  32  Wishbone address.
- wb_sel_o  out  4  Wishbone byte selects.
- wb_dat_o  out  32  Wishbone write data.
- wb_dat_i  in  32  Wishbone read data.
- wb_ack_i, wb_err_i  in  1  cycle termination.

## Operation
- FSM states: IDLE, BUS, RESP. Reset enters IDLE.
- Reset values of all outputs are 0: cmd_ready, rsp_valid, rsp_dat, rsp_err, and all wb_* outputs.
- **IDLE**
  - cmd_ready = 1, combinational from state.
  - On cmd_valid: register we/adr/sel/dat onto the wb_* outputs, set wb_cyc_o = wb_stb_o = 1, go to BUS.
- **BUS**
  - wb_* outputs are held stable until termination.
  - A cycle terminates on the edge where wb_ack_i or wb_err_i is sampled high.
  - On termination: drop wb_cyc_o and wb_stb_o, set rsp_valid = 1, go to RESP.
  - Read with ack: rsp_dat = wb_dat_i, rsp_err = 0.
  - Write with ack: rsp_dat = 0, rsp_err = 0.
  - wb_err_i: rsp_dat = 0, rsp_err = 1. Error takes priority when ack and err are high together.
- **RESP**
  - rsp_valid, rsp_dat and rsp_err are held until rsp_ready is sampled high.
  - Then clear rsp_valid and go to IDLE. cmd_ready stays 0 during RESP.
- Responses are strictly in command order, one outstanding command at a time.
- Outside BUS, wb_we_o, wb_adr_o and wb_sel_o keep their last values; wb_cyc_o and wb_stb_o are 0.

## Timing
- Command accepted at edge N → wb_cyc_o/wb_stb_o high from cycle N+1.
- Responder with one-cycle registered ack (ack high in cycle N+2) → rsp_valid high in cycle N+3.
- After the rsp handshake at edge M, cmd_ready is high in cycle M+1.
- Peak throughput against a one-wait-state responder: one command per 4 cycles.
- Cycle end: wb_stb_o falls on the same edge that samples ack. A responder that gates ack with stb & cyc therefore sees no second ack.
- Reset mid-cycle: wb_cyc_o and wb_stb_o are 0 from the next cycle; the pending response is discarded without a handshake.

## Configuration
- **WB_CMD_MASTER_TIMEOUT_EN defined:**
  - A 16-bit counter clears on entry to BUS and increments each BUS cycle.
  - If it reaches TIMEOUT-1 with neither ack nor err sampled, the cycle aborts like wb_err_i: rsp_err = 1, rsp_dat = 0.
  - An ack arriving on the abort edge wins over the timeout.
- **Undefined:** no counter; BUS waits indefinitely and TIMEOUT is ignored.

## Structure
- Shared package wb_cmd_master_pkg holds:
  - the state enum (IDLE, BUS, RESP);
  - WB_DW = 32, WB_AW = 32, WB_SW = 4;
  - the error-data constant 32'h0.
- One natural sub-module: wb_cmd_master_wdog, the timeout counter with start/abort ports. It is instantiated only under WB_CMD_MASTER_TIMEOUT_EN.

## Test plan
- **Write:** write 32'hA5A5_0000 to 0x14 with sel=4'hF against the GPIO responder → one cycle with wb_we_o=1; rsp_valid in cycle N+3 with rsp_err=0, rsp_dat=0; the GPIO output reads back 32'hA5A5_0000.
- **Read:** with the responder's input pins = 32'h1234_5678, read 0x10 → rsp_dat=32'h1234_5678, rsp_err=0; wb_stb_o is high for exactly 2 cycles.
- **Back-pressure:** hold rsp_ready low for 5 cycles after a read → rsp_valid and rsp_dat stable, cmd_ready=0, no new bus cycle; the handshake then returns cmd_ready=1 in the next cycle.
- **Error priority:** the responder asserts ack and err together → rsp_err=1, rsp_dat=0.
- **Timeout:** macro defined, TIMEOUT=8, silent responder → wb_cyc_o drops after the 8th BUS cycle with rsp_err=1. With the macro undefined, wb_cyc_o stays high for 100 cycles.
- **Reset mid-cycle:** assert reset in the 2nd BUS cycle → all outputs 0 next cycle; a following read completes normally.

Source files
------------

// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the single-outstanding Wishbone command master.
package wb_cmd_master_pkg;
  localparam int WB_DW = 32;
  localparam int WB_AW = 32;
  localparam int WB_SW = 4;

  localparam logic [WB_DW-1:0] WB_ERR_DAT = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/wb_cmd_master_wdog.sv
// Bus-cycle watchdog: counts BUS cycles from a start pulse and flags the cycle
// in which the count reaches TIMEOUT-1.
module wb_cmd_master_wdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_run,
  output logic o_abort
);
  localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)                            r_cnt <= '0;
    else if (i_start)                     r_cnt <= '0;
    else if (i_run && (r_cnt != LP_LAST)) r_cnt <= r_cnt + 16'd1;
  end

  assign o_abort = i_run && (r_cnt == LP_LAST);
endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one command in flight, valid/ready in and out.
// Optional bus watchdog enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_we,
  input  logic [WB_AW-1:0] i_cmd_adr,
  input  logic [WB_SW-1:0] i_cmd_sel,
  input  logic [WB_DW-1:0] i_cmd_dat,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WB_DW-1:0] o_rsp_dat,
  output logic             o_rsp_err,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [WB_AW-1:0] o_wb_adr,
  output logic [WB_SW-1:0] o_wb_sel,
  output logic [WB_DW-1:0] o_wb_dat,
  input  logic [WB_DW-1:0] i_wb_dat,
  input  logic             i_wb_ack,
  input  logic             i_wb_err
);
  state_t r_state, w_next;

  logic             r_cyc, r_stb, r_we;
  logic [WB_AW-1:0] r_adr;
  logic [WB_SW-1:0] r_sel;
  logic [WB_DW-1:0] r_wdat;
  logic             r_rsp_valid, r_rsp_err;
  logic [WB_DW-1:0] r_rsp_dat;

  logic w_accept, w_term, w_abort;

  assign w_accept = (r_state == IDLE) && i_cmd_valid;
  assign w_term   = (r_state == BUS) && (i_wb_ack || i_wb_err || w_abort);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  wb_cmd_master_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_accept),
    .i_run   (r_state == BUS),
    .o_abort (w_abort)
  );
`else
  // No watchdog: TIMEOUT is never 0 in its legal range, so this is constant low.
  assign w_abort = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_cmd_valid) w_next = BUS;
      BUS:     if (w_term)      w_next = RESP;
      RESP:    if (i_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_sel       <= '0;
      r_wdat      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= '0;
    end else begin
      if (w_accept) begin
        r_we   <= i_cmd_we;
        r_adr  <= i_cmd_adr;
        r_sel  <= i_cmd_sel;
        r_wdat <= i_cmd_dat;
        r_cyc  <= 1'b1;
        r_stb  <= 1'b1;
      end
      if (w_term) begin
        r_cyc       <= 1'b0;
        r_stb       <= 1'b0;
        r_rsp_valid <= 1'b1;
        // err beats ack; a watchdog abort (no ack, no err) reports as an error
        if (i_wb_err || !i_wb_ack) begin
          r_rsp_err <= 1'b1;
          r_rsp_dat <= WB_ERR_DAT;
        end else begin
          r_rsp_err <= 1'b0;
          r_rsp_dat <= r_we ? WB_ERR_DAT : i_wb_dat;
        end
      end
      if ((r_state == RESP) && i_rsp_ready) r_rsp_valid <= 1'b0;
    end
  end

  assign o_cmd_ready = (r_state == IDLE) && !reset;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_dat   = r_rsp_dat;
  assign o_rsp_err   = r_rsp_err;
  assign o_wb_cyc    = r_cyc;
  assign o_wb_stb    = r_stb;
  assign o_wb_we     = r_we;
  assign o_wb_adr    = r_adr;
  assign o_wb_sel    = r_sel;
  assign o_wb_dat    = r_wdat;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master against a small GPIO-like Wishbone responder.
module tb_wb_cmd_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_dat;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [31:0] wb_adr, wb_wdat, wb_rdat;
  logic [3:0]  wb_sel;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  // responder state: mode 0 = ack, 1 = ack+err together, 2 = silent
  int          mode = 0;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out;
  logic        r_ack;
  logic [31:0] r_rdat;

  always #5 clk = ~clk;

  wb_cmd_master #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
    .i_cmd_adr(cmd_adr), .i_cmd_sel(cmd_sel), .i_cmd_dat(cmd_dat),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_dat(rsp_dat), .o_rsp_err(rsp_err),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_adr(wb_adr),
    .o_wb_sel(wb_sel), .o_wb_dat(wb_wdat), .i_wb_dat(wb_rdat),
    .i_wb_ack(wb_ack), .i_wb_err(wb_err)
  );

  // one-cycle registered ack, gated with cyc & stb so a held stb cannot re-ack
  always @(posedge clk) begin
    if (reset) begin
      r_ack    <= 1'b0;
      r_rdat   <= '0;
      if (mode == 0) gpio_out <= '0;
    end else begin
      r_ack <= 1'b0;
      if (wb_cyc && wb_stb && !r_ack && mode != 2) begin
        r_ack  <= 1'b1;
        r_rdat <= (wb_adr == 32'h10) ? gpio_in : (wb_adr == 32'h14) ? gpio_out : 32'hDEAD_BEEF;
        if (wb_we && wb_adr == 32'h14)
          for (int b = 0; b < 4; b++)
            if (wb_sel[b]) gpio_out[8*b +: 8] <= wb_wdat[8*b +: 8];
      end
    end
  end
  assign wb_ack  = r_ack;
  assign wb_err  = r_ack && (mode == 1);
  assign wb_rdat = r_rdat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // monitor: every cycle that ends in a response handshake pops one expectation
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_dat", 64'(rsp_dat), 64'(e[32:1]));
        chk("rsp_err", 64'(rsp_err), 64'(e[0]));
      end
    end
  end

  task automatic do_cmd(input string nm, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        input logic [31:0] edat, input logic eerr,
                        input int elat, input int estb, input int bp);
    int n, lat, s;
    logic ok;
    logic [31:0] held_dat;
    logic held_err;
    @(negedge clk);
    cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat; cmd_valid = 1'b1;
    rsp_ready = (bp == 0);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk({nm, "_accept"}, 64'(cmd_ready), 64'd1);
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    exp_q.push_back({edat, eerr});
    @(posedge clk); #1 cmd_valid = 1'b0;
    lat = 0; s = 0;
    do begin
      @(negedge clk); lat++;
      if (wb_stb) s++;
      if (lat == 1) chk({nm, "_wb_req"}, {wb_cyc, wb_we, wb_sel, wb_adr[25:0], wb_wdat[31:0]},
                        {1'b1, we, sel, adr[25:0], we ? dat : wb_wdat});
    end while (!rsp_valid && lat < 200);
    chk({nm, "_latency"}, 64'(lat), 64'(elat));
    chk({nm, "_stb_cycles"}, 64'(s), 64'(estb));
    if (bp > 0) begin
      ok = 1'b1; held_dat = rsp_dat; held_err = rsp_err;
      repeat (bp) begin
        @(negedge clk);
        if (!rsp_valid || rsp_dat !== held_dat || rsp_err !== held_err || cmd_ready || wb_cyc)
          ok = 1'b0;
      end
      chk({nm, "_backpressure_hold"}, 64'(ok), 64'd1);
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_ready_after_rsp"}, {cmd_ready, rsp_valid}, 2'b10);
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_err, rsp_dat, wb_cyc, wb_stb, wb_we, wb_sel},
        '0);
    chk("reset_wb_adr_dat", {wb_adr, wb_wdat}, '0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // write, then read back through the bus
    do_cmd("write", 1'b1, 32'h14, 4'hF, 32'hA5A5_0000, 32'h0, 1'b0, 3, 2, 0);
    chk("gpio_out", 64'(gpio_out), 64'hA5A5_0000);
    do_cmd("readback", 1'b0, 32'h14, 4'hF, 32'h0, 32'hA5A5_0000, 1'b0, 3, 2, 0);

    gpio_in = 32'h1234_5678;
    do_cmd("read", 1'b0, 32'h10, 4'hF, 32'h0, 32'h1234_5678, 1'b0, 3, 2, 0);

    gpio_in = 32'hCAFE_0001;
    do_cmd("bp_read", 1'b0, 32'h10, 4'h3, 32'h0, 32'hCAFE_0001, 1'b0, 3, 2, 5);

    mode = 1;
    do_cmd("err_prio", 1'b0, 32'h10, 4'hF, 32'h0, 32'h0, 1'b1, 3, 2, 0);
    mode = 0;

    // silent responder
    mode = 2;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    do_cmd("timeout", 1'b0, 32'h10, 4'hF, 32'h0, 32'h0, 1'b1, 9, 8, 0);
    mode = 0;
`else
    @(negedge clk);
    cmd_we = 1'b0; cmd_adr = 32'h10; cmd_sel = 4'hF; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    bad = 0;
    repeat (100) begin @(negedge clk); if (!wb_cyc || rsp_valid) bad++; end
    chk("no_timeout_hold", 64'(bad), 64'd0);
    @(posedge clk); #1 reset = 1'b1; mode = 0;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
`endif

    // reset in the 2nd BUS cycle discards the pending read
    @(negedge clk);
    cmd_we = 1'b0; cmd_adr = 32'h10; cmd_sel = 4'hF; cmd_valid = 1'b1; rsp_ready = 1'b1;
    chk("rst_pre_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_bus2", {wb_cyc, wb_stb}, 2'b11);
    @(negedge clk);
    chk("rst_mid_outputs", {cmd_ready, rsp_valid, rsp_err, rsp_dat, wb_cyc, wb_stb, wb_we, wb_sel},
        '0);
    @(posedge clk); #1 reset = 1'b0;
    gpio_in = 32'h0BAD_F00D;
    do_cmd("post_reset_read", 1'b0, 32'h10, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 2, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
